io_bus_fabric: RTL
==================

IO_BUS_FABRIC -- requirements
Module: io_bus_fabric

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8, number of peripheral slots (legal 1..16).
REQ-002 SHALL have parameter PAGE_BASE, default 8'h68, address page (m_addr[15:8]) of slot 0; slot k decodes at PAGE_BASE+k.
REQ-003 SHALL have parameter STATUS_PAGE, default 8'h7F, page of the internal status register.
REQ-004 SHALL have parameter DEFAULT_DATA, default 16'h0666, read data returned for unmapped, timed-out or malformed accesses.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum ACCESS-state cycles before abort (1..65535).
REQ-006 SHALL have sys_clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have sys_rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have m_rd  input  1  CPU read strobe, held while m_stall high.
REQ-009 SHALL have m_wr  input  1  CPU write strobe, held while m_stall high.
REQ-010 SHALL have m_addr  input  16  CPU IO address.
REQ-011 SHALL have m_wdata  input  16  CPU write data.
REQ-012 SHALL have m_rdata  output  16  read data, valid in DONE cycle.
REQ-013 SHALL have m_stall  output  1  wait request to CPU.
REQ-014 SHALL have s_cs  output  N_SLOTS  one-hot registered slot select.
REQ-015 SHALL have s_rd / s_wr  output  1 each  registered strobes, qualified by s_cs.
REQ-016 SHALL have s_addr  output  8  registered m_addr[7:0].
REQ-017 SHALL have s_wdata  output  16  registered write data.
REQ-018 SHALL have s_rdata  input  16*N_SLOTS  flattened slave read data, slot k at bits [16k+15:16k].
REQ-019 SHALL have s_ready  input  N_SLOTS  per-slot completion.
REQ-020 SHALL have irq_err  output  1  sticky bus-error flag.

Function
REQ-021 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-022 IDLE, m_rd^m_wr with mapped page: latch slot, direction, addr, wdata; next state ACCESS; m_stall high combinationally in the request cycle.
REQ-023 ACCESS: s_cs/s_rd/s_wr asserted; m_stall high; on s_ready[slot] capture s_rdata[slot] (reads) and go DONE.
REQ-024 DONE: m_stall low exactly one cycle, m_rdata held, strobes deasserted, then IDLE; requests seen in DONE are not accepted.
REQ-025 Minimum mapped latency: request cycle + 1 ACCESS + DONE = 3 cycles.
REQ-026 Unmapped page (not slot, not STATUS_PAGE): no slave strobe, write dropped, m_rdata=DEFAULT_DATA, go to DONE directly, error code 1.
REQ-027 m_rd and m_wr both high: no slave access, DEFAULT_DATA, DONE directly, error code 3.
REQ-028 STATUS_PAGE read: DONE directly, m_rdata={code[1:0], slot[3:0], 2'b00, count[7:0]}; write: clears code, slot, count, irq_err.
REQ-029 Any error SHALL load code and slot, increment count saturating at 255, set irq_err.
REQ-030 Slots k >= N_SLOTS decode as unmapped.

Reset
REQ-031 On sys_rst_i: state IDLE, s_cs=0, s_rd=s_wr=0, s_addr=0, s_wdata=0, m_rdata=0, status=0, irq_err=0, timeout counter=0.
REQ-032 Reset during ACCESS SHALL deassert all slave strobes on the next edge; the aborted access is not logged as an error.
REQ-033 m_stall SHALL be 0 while sys_rst_i is high.

Configuration
REQ-034 Macro IOFAB_TIMEOUT_EN defined: counter runs in ACCESS; on reaching TIMEOUT without s_ready, abort to DONE, m_rdata=DEFAULT_DATA, error code 2.
REQ-035 IOFAB_TIMEOUT_EN undefined: no counter logic; ACCESS waits indefinitely for s_ready.

Verification
REQ-036 Read addr 16'h6B02, s_ready[3] high first ACCESS cycle, s_rdata[3]=16'hBEEF -> s_cs=8'h08, m_stall 2 cycles, m_rdata=16'hBEEF in DONE.
REQ-037 Write 16'h1234 to 16'h6D00, s_ready[5] after 4 ACCESS cycles -> s_wr high 4 cycles with s_wdata=16'h1234, m_stall 5 cycles total.
REQ-038 Read 16'h7500 -> no s_cs, m_rdata=16'h0666, irq_err=1; read 16'h7F00 -> 16'h4000|count 1 (code 1, slot 0, count 1).
REQ-039 With IOFAB_TIMEOUT_EN, TIMEOUT=255, read slot 2 with s_ready low -> abort after 255 ACCESS cycles, m_rdata=16'h0666, status code 2 slot 2.
REQ-040 Write 16'h0000 to 16'h7F00 after errors -> status reads 16'h0000, irq_err=0; 300 unmapped reads -> count saturates 8'hFF.
REQ-041 Assert sys_rst_i during ACCESS -> s_cs=0, m_stall=0 next cycle, status unchanged at 0.

Source files
------------

// File: rtl/io_bus_fabric.sv
// io_bus_fabric: single-master IO bus fabric that decodes CPU IO accesses onto
// N_SLOTS peripheral slots, one 256-byte page per slot, plus an internal status
// register at STATUS_PAGE.
//
// Ports:
//   sys_clk_i, sys_rst_i    clock and synchronous active-high reset
//   m_rd, m_wr              CPU strobes, held while m_stall is high
//   m_addr, m_wdata         CPU address and write data
//   m_rdata                 read data, valid in the DONE cycle
//   m_stall                 combinational wait request to the CPU
//   s_cs, s_rd, s_wr        registered one-hot slot select and strobes
//   s_addr, s_wdata         registered low address byte and write data
//   s_rdata, s_ready        flattened per-slot read data and completion
//   irq_err                 sticky bus-error flag, cleared by a status write
//
// Status register: {code[1:0], slot[3:0], 2'b00, count[7:0]}.
// Error codes: 1 = unmapped page, 2 = timeout, 3 = m_rd and m_wr both high.
//
// Optional feature: define IOFAB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles
// without s_ready. Without it, ACCESS waits indefinitely.

module io_bus_fabric #(
   parameter int unsigned  N_SLOTS      = 8,
   parameter logic [7:0]   PAGE_BASE    = 8'h68,
   parameter logic [7:0]   STATUS_PAGE  = 8'h7F,
   parameter logic [15:0]  DEFAULT_DATA = 16'h0666,
   parameter int unsigned  TIMEOUT      = 255
) (
   input  logic                   sys_clk_i,
   input  logic                   sys_rst_i,
   input  logic                   m_rd,
   input  logic                   m_wr,
   input  logic [15:0]            m_addr,
   input  logic [15:0]            m_wdata,
   output logic [15:0]            m_rdata,
   output logic                   m_stall,
   output logic [N_SLOTS-1:0]     s_cs,
   output logic                   s_rd,
   output logic                   s_wr,
   output logic [7:0]             s_addr,
   output logic [15:0]            s_wdata,
   input  logic [16*N_SLOTS-1:0]  s_rdata,
   input  logic [N_SLOTS-1:0]     s_ready,
   output logic                   irq_err
);

   if (N_SLOTS < 1 || N_SLOTS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("io_bus_fabric: N_SLOTS or TIMEOUT out of range");
   end

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e               state_q;
   logic [3:0]           slot_q;
   logic [1:0]           code_q;
   logic [3:0]           eslot_q;
   logic [7:0]           count_q;
`ifdef IOFAB_TIMEOUT_EN
   logic [15:0]          tcnt_q;
`endif

   logic [8:0]           page_diff;
   logic [3:0]           req_slot;
   logic                 req_any;
   logic                 req_mapped;
   logic                 req_status;
   logic [N_SLOTS-1:0]   cs_dec;
   logic [15:0]          sel_rdata;
   logic                 sel_ready;
   logic [7:0]           count_inc;

   // 9-bit difference so pages below PAGE_BASE never wrap into a slot.
   assign page_diff  = {1'b0, m_addr[15:8]} - {1'b0, PAGE_BASE};
   assign req_slot   = page_diff[3:0];
   assign req_mapped = !page_diff[8] && (page_diff[7:0] < 8'(N_SLOTS));
   assign req_status = (m_addr[15:8] == STATUS_PAGE);
   assign req_any    = m_rd | m_wr;
   assign count_inc  = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

   // Stall covers the request cycle and every ACCESS cycle; DONE is the release.
   assign m_stall = !sys_rst_i &&
                    ((state_q == StAccess) || ((state_q == StIdle) && req_any));

   always_comb begin
      cs_dec = '0;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
         cs_dec[k] = (req_slot == 4'(k));
      end
   end

   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
         if (slot_q == 4'(k)) begin
            sel_rdata = s_rdata[16*k +: 16];
            sel_ready = s_ready[k];
         end
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q <= StIdle;
         slot_q  <= '0;
         s_cs    <= '0;
         s_rd    <= 1'b0;
         s_wr    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         m_rdata <= '0;
         code_q  <= '0;
         eslot_q <= '0;
         count_q <= '0;
         irq_err <= 1'b0;
`ifdef IOFAB_TIMEOUT_EN
         tcnt_q  <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_any) begin
                  if (m_rd && m_wr) begin
                     m_rdata <= DEFAULT_DATA;
                     code_q  <= 2'd3;
                     eslot_q <= 4'd0;
                     count_q <= count_inc;
                     irq_err <= 1'b1;
                     state_q <= StDone;
                  end else if (req_status) begin
                     if (m_rd) begin
                        m_rdata <= {code_q, eslot_q, 2'b00, count_q};
                     end else begin
                        code_q  <= '0;
                        eslot_q <= '0;
                        count_q <= '0;
                        irq_err <= 1'b0;
                     end
                     state_q <= StDone;
                  end else if (req_mapped) begin
                     slot_q  <= req_slot;
                     s_cs    <= cs_dec;
                     s_rd    <= m_rd;
                     s_wr    <= m_wr;
                     s_addr  <= m_addr[7:0];
                     s_wdata <= m_wdata;
`ifdef IOFAB_TIMEOUT_EN
                     tcnt_q  <= '0;
`endif
                     state_q <= StAccess;
                  end else begin
                     m_rdata <= DEFAULT_DATA;
                     code_q  <= 2'd1;
                     eslot_q <= 4'd0;
                     count_q <= count_inc;
                     irq_err <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StAccess: begin
               if (sel_ready) begin
                  if (s_rd) m_rdata <= sel_rdata;
                  s_cs    <= '0;
                  s_rd    <= 1'b0;
                  s_wr    <= 1'b0;
                  state_q <= StDone;
`ifdef IOFAB_TIMEOUT_EN
               end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
                  // This is the TIMEOUT-th ACCESS cycle without completion.
                  m_rdata <= DEFAULT_DATA;
                  code_q  <= 2'd2;
                  eslot_q <= slot_q;
                  count_q <= count_inc;
                  irq_err <= 1'b1;
                  s_cs    <= '0;
                  s_rd    <= 1'b0;
                  s_wr    <= 1'b0;
                  state_q <= StDone;
               end else begin
                  tcnt_q  <= tcnt_q + 16'd1;
`endif
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
